// File: rtl/ysyx_22050550_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the reset PC and the fixed memory beat width.
package ysyx_22050550_ifu_pkg;

  localparam int unsigned BEAT_W = 64;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  // IDLE after reset, ADDR while the read address is offered, DATA while
  // waiting for the read beat, OUT while the instruction is offered to ID.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22050550_ifu_if.sv
// Bus bundle of the fetch unit: AXI-style read channel towards instruction
// memory plus the instruction channel towards ID.
//
// Handshake rule for every valid/ready pair here (ar, r, if): a transfer
// happens on a rising clock edge where both valid and ready are high; once
// valid is raised, the payload holds stable until that transfer (or, on the
// if channel only, until an ID redirect withdraws it).
interface ysyx_22050550_ifu_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  import ysyx_22050550_ifu_pkg::*;

  logic              imem_arvalid;
  logic              imem_arready;
  logic [ADDR_W-1:0] imem_araddr;
  logic              imem_rvalid;
  logic              imem_rready;
  logic [BEAT_W-1:0] imem_rdata;
  logic [1:0]        imem_rresp;

  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_fault;

  modport master (
    output imem_arvalid, imem_araddr, imem_rready,
    input  imem_arready, imem_rvalid, imem_rdata, imem_rresp,
    output if_valid, if_pc, if_inst, if_fault,
    input  if_ready
  );

  modport slave (
    input  imem_arvalid, imem_araddr, imem_rready,
    output imem_arready, imem_rvalid, imem_rdata, imem_rresp,
    input  if_valid, if_pc, if_inst, if_fault,
    output if_ready
  );

endinterface

// File: rtl/ysyx_22050550_ifu_wsel.sv
// Picks the 32-bit instruction out of a 64-bit memory beat and masks it to
// zero when the memory reports an error.
module ysyx_22050550_ifu_wsel
  import ysyx_22050550_ifu_pkg::*;
(
  input  logic [BEAT_W-1:0] rdata_i,
  input  logic              hi_i,
  input  logic [1:0]        rresp_i,
  output logic [31:0]       inst_o,
  output logic              fault_o
);

  // Upper word for address bit 2 set, lower word otherwise; zero on error.
  always_comb begin
    fault_o = (rresp_i != 2'b00);
    inst_o  = hi_i ? rdata_i[63:32] : rdata_i[31:0];
    if (fault_o) begin
      inst_o = 32'h0;
    end
  end

endmodule

// File: rtl/ysyx_22050550_ifu.sv
// Instruction fetch unit: one memory read per instruction, instruction
// handed to ID over valid/ready, PC advance requested on each handoff.
// ID redirects kill any wrong-path fetch: a read already in flight is
// allowed to finish and its beat is thrown away before refetching.
module ysyx_22050550_ifu
  import ysyx_22050550_ifu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              redirect,
  output logic              pc_ready,
  ysyx_22050550_ifu_if.master bus,
  output ifu_state_e        state_o
);

  ifu_state_e        state_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              kill_q;
  logic [ADDR_W-1:0] redir_pc_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [31:0]       if_inst_q;
  logic              if_fault_q;

  logic [31:0]       sel_inst;
  logic              sel_fault;

  ysyx_22050550_ifu_wsel u_wsel (
    .rdata_i (bus.imem_rdata),
    .hi_i    (araddr_q[2]),
    .rresp_i (bus.imem_rresp),
    .inst_o  (sel_inst),
    .fault_o (sel_fault)
  );

  // Channel strobes decode straight from the state register; a redirect
  // withdraws the held instruction in the same cycle so it cannot hand off.
  assign bus.imem_arvalid = (state_q == S_ADDR);
  assign bus.imem_rready  = (state_q == S_DATA);
  assign bus.imem_araddr  = araddr_q;
  assign bus.if_valid     = (state_q == S_OUT) && !redirect;
  assign bus.if_pc        = if_pc_q;
  assign bus.if_inst      = INST_W'(if_inst_q);
  assign bus.if_fault     = if_fault_q;
  assign pc_ready         = bus.if_valid && bus.if_ready;
  assign state_o          = state_q;

  // Fetch sequencer: address phase, data phase, offer to ID, with the kill
  // flag remembering that the read in flight belongs to a wrong path.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      araddr_q   <= '0;
      kill_q     <= 1'b0;
      redir_pc_q <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          araddr_q <= pc_in;
          state_q  <= S_ADDR;
        end
        S_ADDR: begin
          // araddr must stay put while arvalid is up; remember the target.
          if (redirect) begin
            kill_q     <= 1'b1;
            redir_pc_q <= pc_in;
          end
          if (bus.imem_arready) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.imem_rvalid) begin
            kill_q <= 1'b0;
            if (redirect) begin
              araddr_q <= pc_in;
              state_q  <= S_ADDR;
            end else if (kill_q) begin
              araddr_q <= redir_pc_q;
              state_q  <= S_ADDR;
            end else begin
              if_pc_q    <= araddr_q;
              if_inst_q  <= sel_inst;
              if_fault_q <= sel_fault;
              state_q    <= S_OUT;
            end
          end else if (redirect) begin
            kill_q     <= 1'b1;
            redir_pc_q <= pc_in;
          end
        end
        S_OUT: begin
          if (redirect) begin
            araddr_q <= pc_in;
            state_q  <= S_ADDR;
          end else if (bus.if_ready) begin
            araddr_q <= if_pc_q + ADDR_W'(4);
            state_q  <= S_ADDR;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_ifu.sv
// Randomized bench for the fetch unit: a behavioural instruction memory,
// a PC-register model, a randomized ID stage, and a transaction-level
// expectation of which PC ID should see next.
module tb_ysyx_22050550_ifu;
  import ysyx_22050550_ifu_pkg::*;

  localparam int ADDR_W = 64;
  localparam int INST_W = 32;
  localparam int GAP_LIMIT = 400;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [63:0] pc_in;
  logic       redirect;
  logic       pc_ready;
  ifu_state_e state_dbg;

  always #5 clock = ~clock;

  ysyx_22050550_ifu_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  ysyx_22050550_ifu #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .pc_in    (pc_in),
    .redirect (redirect),
    .pc_ready (pc_ready),
    .bus      (bus),
    .state_o  (state_dbg)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ho  = 0;

  logic [63:0] exp_q[$];      // PC that ID must receive next
  logic [63:0] mem_q[$];      // accepted read addresses awaiting a beat
  int          mem_dly;
  logic [63:0] pc_reg;        // PC register model
  logic [63:0] fetch_addr;    // address the current fetch started with
  logic [63:0] redir_tgt;
  bit          held;          // an instruction should be on offer to ID
  bit          clean;         // no redirect since the current fetch began
  bit          idle_cyc;

  int unsigned p_ar, max_dly, p_ifr, p_redir;
  bit          hi_tgt;

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- memory contents ----------------
  function automatic logic [31:0] mem_word(input logic [63:0] widx);
    if (widx == 64'h2000_0000) return 32'h0000_0013;
    if (widx == 64'h2000_0001) return 32'h0010_0093;
    return (widx[31:0] * 32'h9E37_79B1) ^ widx[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit mem_fault(input logic [63:0] a);
    return ((a >> 3) % 64'd9) == 64'd4;
  endfunction

  function automatic logic [63:0] pick_target(input bit hi);
    logic [63:0] t;
    if (hi) t = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 7)) * 64'd4;
    else    t = RESET_PC + 64'($urandom_range(0, 255)) * 64'd4;
    if ($urandom_range(0, 9) == 0) t = t + 64'($urandom_range(1, 3));
    return t;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_inputs();
    logic [63:0] a;
    logic [63:0] bidx;
    @(posedge clock);
    #1;
    reset = 1'b0;
    if (mem_q.size() > 0 && mem_dly == 0) begin
      a    = mem_q[0];
      bidx = (a >> 3) << 1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = {mem_word(bidx | 64'd1), mem_word(bidx)};
      bus.imem_rresp  = mem_fault(a) ? 2'($urandom_range(1, 3)) : 2'b00;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = {$urandom, $urandom};
      bus.imem_rresp  = 2'($urandom_range(0, 3));
    end
    bus.imem_arready = ($urandom_range(0, 99) < p_ar);
    bus.if_ready     = ($urandom_range(0, 99) < p_ifr);
    redirect         = !idle_cyc && ($urandom_range(0, 99) < p_redir);
    redir_tgt        = pick_target(hi_tgt);
    pc_in            = redirect ? redir_tgt : pc_reg;
  endtask

  // ---------------- sample, compare, advance model ----------------
  task automatic sample_and_commit();
    bit exp_valid, exp_pr, exp_ar, r_hs;
    logic [63:0] p;
    @(negedge clock);
    cyc++;
    exp_valid = held && !redirect;
    exp_pr    = exp_valid && bus.if_ready;
    exp_ar    = !held && mem_q.size() == 0 && !idle_cyc;
    check_eq("if_valid", 64'(bus.if_valid), 64'(exp_valid));
    check_eq("pc_ready", 64'(pc_ready), 64'(exp_pr));
    check_eq("arvalid", 64'(bus.imem_arvalid), 64'(exp_ar));
    check_eq("rready", 64'(bus.imem_rready), 64'(mem_q.size() != 0));
    if (exp_ar) check_eq("araddr", bus.imem_araddr, fetch_addr);
    if (held) begin
      p = exp_q[0];
      check_eq("if_pc", bus.if_pc, p);
      check_eq("if_fault", 64'(bus.if_fault), 64'(mem_fault(p)));
      check_eq("if_inst", 64'(bus.if_inst), mem_fault(p) ? 64'd0 : 64'(mem_word(p >> 2)));
    end
    if (exp_pr) last_ho = cyc;
    if (cyc - last_ho > GAP_LIMIT) begin
      check_eq("handoff_gap", 64'(cyc - last_ho), 64'(GAP_LIMIT));
      last_ho = cyc;
    end

    r_hs = bus.imem_rvalid && bus.imem_rready;
    // PC register and expected-PC scoreboard
    if (redirect) begin
      pc_reg = redir_tgt;
      exp_q.delete();
      exp_q.push_back(redir_tgt);
    end else if (exp_pr) begin
      pc_reg = pc_reg + 64'd4;
      void'(exp_q.pop_front());
      exp_q.push_back(pc_reg);
    end
    // fetch lifecycle
    if (held) begin
      if (redirect || exp_pr) begin
        held = 1'b0;
        clean = 1'b1;
        fetch_addr = pc_reg;
      end
    end else if (r_hs) begin
      if (clean && !redirect) held = 1'b1;
      else begin
        clean = 1'b1;
        fetch_addr = pc_reg;
      end
    end else if (redirect) begin
      clean = 1'b0;
    end
    // memory
    if (r_hs) void'(mem_q.pop_front());
    else if (mem_q.size() > 0 && mem_dly > 0) mem_dly--;
    if (bus.imem_arvalid && bus.imem_arready) begin
      mem_q.push_back(bus.imem_araddr);
      mem_dly = int'($urandom_range(0, max_dly));
    end
    idle_cyc = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    redirect = 1'b0;
    pc_in = RESET_PC;
    bus.if_ready = 1'b0;
    bus.imem_arready = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.imem_rresp = 2'b00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_araddr", bus.imem_araddr, 64'd0);
    check_eq("rst_arvalid", 64'(bus.imem_arvalid), 64'd0);
    check_eq("rst_rready", 64'(bus.imem_rready), 64'd0);
    check_eq("rst_if_valid", 64'(bus.if_valid), 64'd0);
    check_eq("rst_if_pc", bus.if_pc, 64'd0);
    check_eq("rst_if_inst", 64'(bus.if_inst), 64'd0);
    check_eq("rst_if_fault", 64'(bus.if_fault), 64'd0);
    check_eq("rst_pc_ready", 64'(pc_ready), 64'd0);
    check_eq("rst_state", 64'(state_dbg), 64'(S_IDLE));
    mem_q.delete();
    mem_dly = 0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    pc_reg = RESET_PC;
    fetch_addr = RESET_PC;
    held = 1'b0;
    clean = 1'b1;
    idle_cyc = 1'b1;
    last_ho = cyc;
  endtask

  task automatic run_phase(input int n, input int unsigned ar, input int unsigned dly,
                           input int unsigned ifr, input int unsigned rd, input bit hi);
    p_ar = ar; max_dly = dly; p_ifr = ifr; p_redir = rd; hi_tgt = hi;
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      sample_and_commit();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    run_phase(40, 100, 0, 100, 0, 1'b0);    // zero-wait, 3 cycles per instruction
    run_phase(150, 100, 0, 15, 0, 1'b0);    // ID mostly stalling
    run_phase(1500, 60, 3, 60, 8, 1'b0);    // mixed traffic with redirects
    run_phase(600, 50, 4, 50, 20, 1'b1);    // targets near the top, PC wrap
    run_phase(37, 40, 3, 50, 10, 1'b0);
    do_reset();                             // reset in the middle of traffic
    run_phase(40, 100, 0, 100, 0, 1'b0);
    run_phase(800, 40, 3, 70, 15, 1'b0);    // frequent redirects, slow arready
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
